uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg_if.sv | 23 ++
 rtl/uart_tx_cfg.sv | 111 +++++++++++
 tb/tb_uart_tx_cfg.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Transmit-side bundle of the configurable UART: byte write handshake, FIFO level and line status.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]         TX_in;
  logic                         TX_valid;
  logic                         TX_rdy;
  logic [$clog2(FIFO_DEPTH):0]  TX_level;
  logic                         TX_busy;
  logic                         TX_done;
  logic                         TX_out;

  modport master (
    output TX_in, TX_valid,
    input  TX_rdy, TX_level, TX_busy, TX_done, TX_out
  );

  modport slave (
    input  TX_in, TX_valid,
    output TX_rdy, TX_level, TX_busy, TX_done, TX_out
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small write FIFO and a compile-time frame format (data bits, parity, stop bits).
// Start bit leaves one clk after the FSM sees a non-empty FIFO; queued frames chain with no idle gap.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         TX_rst,
  uart_tx_cfg_if.slave bus
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int IW  = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        count_q;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 full, push, pop, tick, last_data, last_stop;

  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign push      = bus.TX_valid && !full;
  assign tick      = (baud_q == CW'(DIV - 1));
  assign last_data = (bit_idx_q == IW'(DATA_BITS - 1));
  assign last_stop = (bit_idx_q == IW'(STOP_BITS - 1));
  // Pop either from idle or on the final stop tick, so back-to-back frames have no gap.
  assign pop       = (count_q != '0) &&
                     ((state_q == IDLE) || (state_q == STOP && tick && last_stop));

  assign bus.TX_rdy   = !full;
  assign bus.TX_level = count_q;

  always_ff @(posedge clk) begin
    if (TX_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && last_data) state_d = (PARITY != 0) ? PAR : STOP;
      PAR:     if (tick) state_d = STOP;
      STOP:    if (tick && last_stop) state_d = (count_q != '0) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.TX_out = 1'b1;
    unique case (state_q)
      START:   bus.TX_out = 1'b0;
      DATA:    bus.TX_out = shreg_q[0];
      PAR:     bus.TX_out = par_q;
      default: bus.TX_out = 1'b1;
    endcase
    bus.TX_busy = (state_q != IDLE);
    bus.TX_done = (state_q == STOP) && tick && last_stop;
  end

  always_comb begin
    baud_d    = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    if (tick) bit_idx_d = (state_d == state_q) ? bit_idx_q + 1'b1 : '0;
    shreg_d   = shreg_q;
    par_d     = par_q;
    if (pop) begin
      shreg_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
    end else if (state_q == DATA && tick) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !TX_rst) mem_q[wr_ptr_q] <= bus.TX_in;
  end

  always_ff @(posedge clk) begin
    if (TX_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_q + LW'(push) - LW'(pop);
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Four transmitter instances (8N1, 8E1, 8O1, 7O2, DIV=10) checked by per-instance line monitors
// against a scoreboard of expected frames.
module tb_uart_tx_cfg;
  localparam int DIV = 10;

  typedef struct {
    int          cfg;
    logic [15:0] bits;
    int          len;
  } exp_t;

  function automatic int cfg_db(int g);  return (g == 3) ? 7 : 8; endfunction
  function automatic int cfg_par(int g); return (g == 1) ? 2 : ((g == 0) ? 0 : 1); endfunction
  function automatic int cfg_sb(int g);  return (g == 3) ? 2 : 1; endfunction
  function automatic int cfg_len(int g);
    return 1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g);
  endfunction

  function automatic exp_t model_frame(int g, logic [8:0] d);
    exp_t e;
    int   n, ones;
    e.cfg = g;
    e.bits = 16'hFFFF;
    e.bits[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < cfg_db(g); i++) begin
      e.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (cfg_par(g) != 0) begin
      e.bits[n] = (cfg_par(g) == 1) ? ~ones[0] : ones[0];
      n++;
    end
    e.len = n + cfg_sb(g);
    return e;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [8:0] din [4];
  logic       vld [4];
  logic       rst [4];
  logic       mon_en [4];
  logic       rdy [4];
  logic       busy [4];
  logic       done [4];
  logic       txo [4];
  logic [2:0] level [4];
  int         nframes [4];
  int         nstart [4];
  int         start_log [4][16];
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = cfg_db(g);

    uart_tx_cfg_if #(.DATA_BITS(DB), .FIFO_DEPTH(4)) bus ();

    uart_tx_cfg #(
      .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(DB),
      .PARITY(cfg_par(g)), .STOP_BITS(cfg_sb(g)), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk),
      .TX_rst(rst[g]),
      .bus(bus)
    );

    assign bus.TX_in    = din[g][DB-1:0];
    assign bus.TX_valid = vld[g];
    assign rdy[g]       = bus.TX_rdy;
    assign busy[g]      = bus.TX_busy;
    assign done[g]      = bus.TX_done;
    assign txo[g]       = bus.TX_out;
    assign level[g]     = bus.TX_level;

    // Line monitor: frame starts on a low TX_out, then every cycle is compared to the expected bit.
    initial begin : mon
      int       pos, idx, bad_pos;
      exp_t     cur;
      bit       bad;
      logic     exp_bit, exp_done;
      logic [2:0] bad_got, bad_exp;
      pos = -1;
      bad = 1'b0;
      bad_pos = 0;
      bad_got = '0;
      bad_exp = '0;
      forever begin
        @(negedge clk);
        if (rst[g] === 1'b1 || mon_en[g] !== 1'b1) begin
          pos = -1;
          if (rst[g] === 1'b1)
            for (int i = exp_q.size() - 1; i >= 0; i--)
              if (exp_q[i].cfg == g) exp_q.delete(i);
        end else begin
          if (pos < 0 && txo[g] === 1'b0) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
              if (idx < 0 && exp_q[i].cfg == g) idx = i;
            if (idx >= 0) begin
              cur = exp_q[idx];
              exp_q.delete(idx);
            end else begin
              cur.cfg = g;
              cur.bits = 16'hFFFF;
              cur.len = cfg_len(g);
            end
            if (nstart[g] < 16) start_log[g][nstart[g]] = cyc;
            nstart[g]++;
            pos = 0;
            bad = 1'b0;
          end
          if (pos >= 0) begin
            exp_bit  = cur.bits[pos / DIV];
            exp_done = (pos == cur.len * DIV - 1);
            if (!bad && (txo[g] !== exp_bit || busy[g] !== 1'b1 || done[g] !== exp_done)) begin
              bad = 1'b1;
              bad_pos = pos;
              bad_got = {txo[g], busy[g], done[g]};
              bad_exp = {exp_bit, 1'b1, exp_done};
            end
            pos++;
            if (pos == cur.len * DIV) begin
              checks++;
              if (bad) begin
                errors++;
                $display("FAIL frame cfg%0d at frame cycle %0d out/busy/done got %b required %b (frame bits %h)",
                         g, bad_pos, bad_got, bad_exp, cur.bits);
              end
              nframes[g]++;
              pos = -1;
            end
          end else begin
            checks++;
            if (txo[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
              errors++;
              $display("FAIL idle cfg%0d cycle %0d out/busy/done got %b%b%b required 100",
                       g, cyc, txo[g], busy[g], done[g]);
            end
          end
        end
      end
    end
  end

  task automatic send(int g, logic [8:0] d, output int acc);
    @(posedge clk);
    #1;
    din[g] = d;
    vld[g] = 1'b1;
    @(posedge clk);
    #1;
    vld[g] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_frames(int g, int n, int budget);
    int k;
    k = 0;
    while (nframes[g] < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (nframes[g] < n) begin
      errors++;
      $display("FAIL timeout cfg%0d frames got %0d required %0d", g, nframes[g], n);
    end
  endtask

  task automatic push_literal(int g, logic [15:0] bits, int len);
    exp_t e;
    e.cfg = g;
    e.bits = bits;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    for (int g = 0; g < 4; g++) begin
      rst[g] = 1'b1;
      vld[g] = 1'b0;
      din[g] = '0;
      mon_en[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) rst[g] = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++; if (txo[g] !== 1'b1)   begin errors++; $display("FAIL reset_out cfg%0d got %b required 1", g, txo[g]); end
      checks++; if (busy[g] !== 1'b0)  begin errors++; $display("FAIL reset_busy cfg%0d got %b required 0", g, busy[g]); end
      checks++; if (done[g] !== 1'b0)  begin errors++; $display("FAIL reset_done cfg%0d got %b required 0", g, done[g]); end
      checks++; if (rdy[g] !== 1'b1)   begin errors++; $display("FAIL reset_rdy cfg%0d got %b required 1", g, rdy[g]); end
      checks++; if (level[g] !== 3'd0) begin errors++; $display("FAIL reset_level cfg%0d got %0d required 0", g, level[g]); end
      mon_en[g] = 1'b1;
    end
  endtask

  task automatic test_8n1();
    int acc, f0, s0;
    f0 = nframes[0];
    s0 = nstart[0];
    push_literal(0, {6'h3F, 10'b1101001010}, 10);
    send(0, 9'h0A5, acc);
    wait_frames(0, f0 + 1, 300);
    checks++;
    if (start_log[0][s0] !== acc + 1) begin
      errors++;
      $display("FAIL start_latency got cycle %0d required %0d", start_log[0][s0], acc + 1);
    end
  endtask

  task automatic test_parity();
    int acc, f1, f2;
    f1 = nframes[1];
    f2 = nframes[2];
    push_literal(1, {5'h1F, 11'b11000001110}, 11);
    send(1, 9'h007, acc);
    push_literal(2, {5'h1F, 11'b10000001110}, 11);
    send(2, 9'h007, acc);
    wait_frames(1, f1 + 1, 300);
    wait_frames(2, f2 + 1, 300);
  endtask

  task automatic test_7o2();
    int acc, f3;
    f3 = nframes[3];
    push_literal(3, {5'h1F, 11'b11110101010}, 11);
    send(3, 9'h055, acc);
    wait_frames(3, f3 + 1, 300);
  endtask

  task automatic test_random();
    int acc, f;
    logic [8:0] v;
    for (int g = 1; g < 4; g++) begin
      f = nframes[g];
      for (int k = 0; k < 2; k++) begin
        v = 9'($urandom_range(0, (1 << cfg_db(g)) - 1));
        exp_q.push_back(model_frame(g, v));
        send(g, v, acc);
      end
      wait_frames(g, f + 2, 400);
    end
  endtask

  task automatic test_back_to_back();
    int f0, s0, d;
    f0 = nframes[0];
    s0 = nstart[0];
    for (int k = 1; k <= 5; k++) exp_q.push_back(model_frame(0, 9'(k)));
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      din[0] = 9'(k);
      vld[0] = 1'b1;
      checks++;
      if (rdy[0] !== (k <= 5)) begin
        errors++;
        $display("FAIL rdy_before_write%0d got %b required %b", k, rdy[0], (k <= 5));
      end
      @(posedge clk);
    end
    #1;
    vld[0] = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0 || level[0] !== 3'd4) begin
      errors++;
      $display("FAIL full_state rdy/level got %b/%0d required 0/4", rdy[0], level[0]);
    end
    wait_frames(0, f0 + 5, 700);
    for (int i = 1; i < 5; i++) begin
      d = start_log[0][s0 + i] - start_log[0][s0 + i - 1];
      checks++;
      if (d !== 100) begin
        errors++;
        $display("FAIL frame_gap %0d got %0d cycles required 100", i, d);
      end
    end
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (nframes[0] !== f0 + 5 || level[0] !== 3'd0) begin
      errors++;
      $display("FAIL drain frames/level got %0d/%0d required %0d/0", nframes[0], level[0], f0 + 5);
    end
  endtask

  task automatic test_reset_midframe();
    int f0, s0, s, k;
    f0 = nframes[0];
    s0 = nstart[0];
    exp_q.push_back(model_frame(0, 9'h011));
    exp_q.push_back(model_frame(0, 9'h022));
    exp_q.push_back(model_frame(0, 9'h033));
    @(posedge clk); #1; din[0] = 9'h011; vld[0] = 1'b1;
    @(posedge clk); #1; din[0] = 9'h022;
    @(posedge clk); #1; din[0] = 9'h033;
    @(posedge clk); #1; vld[0] = 1'b0;
    checks++;
    if (nstart[0] !== s0 + 1 || level[0] !== 3'd2) begin
      errors++;
      $display("FAIL queued_before_reset starts/level got %0d/%0d required %0d/2", nstart[0], level[0], s0 + 1);
    end
    s = start_log[0][s0];
    k = 0;
    while (cyc < s + 35 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    rst[0] = 1'b1;
    din[0] = 9'h044;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    checks++;
    if (txo[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_line out/busy/done got %b%b%b required 100", txo[0], busy[0], done[0]);
    end
    checks++;
    if (level[0] !== 3'd0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_fifo level/rdy got %0d/%b required 0/1", level[0], rdy[0]);
    end
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (nframes[0] !== f0 || nstart[0] !== s0 + 1) begin
      errors++;
      $display("FAIL after_abort frames/starts got %0d/%0d required %0d/%0d", nframes[0], nstart[0], f0, s0 + 1);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7o2();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d frames required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
